// File: rtl/data_cache_pkg.sv
// Shared types and default field widths for the data cache.
// The FSM state encoding lives here so the bench and RTL agree.
package data_cache_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_OFF_W     = 2;
  localparam int DEF_WORD_OFF_W = 2;
  localparam int DEF_INDEX_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    RESPOND
  } state_t;

endpackage

// File: rtl/data_cache_line_array.sv
// Tag/data/valid/dirty storage with a combinational read port
// and a synchronous write port.
module cache_line_array #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 24,
  parameter int LINE_W   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Payload needs no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache
// with a single outstanding line transaction.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS       = 1 << DEF_INDEX_W,
  parameter int WORDS_PER_LINE = 1 << DEF_WORD_OFF_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             is_input_valid,
  input  logic [31:0]                      addr,
  input  logic                             mem_read,
  input  logic                             mem_write,
  input  logic [31:0]                      din,
  output logic                             is_ready,
  output logic                             is_output_valid,
  output logic [31:0]                      dout,
  output logic                             is_hit,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_write,
  output logic [31:0]                      mem_req_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0] mem_req_wdata,
  input  logic                             mem_resp_valid,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_resp_rdata
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int LO_W   = BYTE_OFF_W + WOFF_W;
  localparam int TAG_W  = WORD_W - LO_W - IDX_W;

  state_t state, state_n;

  logic [31:BYTE_OFF_W] req_addr;
  logic [31:0]          req_din;
  logic                 req_write;
  logic                 req_sent;

  logic [WOFF_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic [31:0]       rd_word;
  logic [LINE_W-1:0] wr_line;
  logic              hit, accept;

  logic              arr_we, arr_valid, arr_dirty;
  logic [LINE_W-1:0] arr_data;

  wire unused_byte_off = ^addr[BYTE_OFF_W-1:0];

  assign req_word = req_addr[LO_W-1:BYTE_OFF_W];
  assign req_idx  = req_addr[LO_W+IDX_W-1:LO_W];
  assign req_tag  = req_addr[31:LO_W+IDX_W];

  assign is_ready = reset & (state == IDLE);
  assign accept   = is_ready & is_input_valid
                  & (mem_read | mem_write);

  assign hit     = rd_valid & (rd_tag == req_tag);
  assign rd_word = rd_data[req_word*WORD_W +: WORD_W];
  assign mem_req_wdata = rd_data;

  always_comb begin
    wr_line = rd_data;
    wr_line[req_word*WORD_W +: WORD_W] = req_din;
  end

  cache_line_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_W)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (arr_we),
    .wr_idx   (req_idx),
    .wr_valid (arr_valid),
    .wr_dirty (arr_dirty),
    .wr_tag   (req_tag),
    .wr_data  (arr_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_din   <= '0;
      req_write <= 1'b0;
      req_sent  <= 1'b0;
    end else begin
      state    <= state_n;
      req_sent <= (state == ALLOCATE)
                & (req_sent | mem_req_ready);
      if (accept) begin
        req_addr  <= addr[31:BYTE_OFF_W];
        req_din   <= din;
        req_write <= mem_write;
      end
    end
  end

  always_comb begin
    state_n         = state;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = {req_tag, req_idx, {LO_W{1'b0}}};
    arr_we          = 1'b0;
    arr_valid       = 1'b1;
    arr_dirty       = 1'b1;
    arr_data        = wr_line;
    unique case (state)
      IDLE: begin
        if (accept) state_n = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          is_output_valid = 1'b1;
          is_hit          = 1'b1;
          dout            = req_write ? '0 : rd_word;
          arr_we          = req_write;
          state_n         = IDLE;
        end else if (rd_valid & rd_dirty) begin
          state_n = WRITEBACK;
        end else begin
          state_n = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {rd_tag, req_idx, {LO_W{1'b0}}};
        if (mem_req_ready) state_n = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = ~req_sent;
        if (req_sent & mem_resp_valid) begin
          arr_we    = 1'b1;
          arr_dirty = 1'b0;
          arr_data  = mem_resp_rdata;
          state_n   = RESPOND;
        end
      end
      RESPOND: begin
        is_output_valid = 1'b1;
        dout            = req_write ? '0 : rd_word;
        arr_we          = req_write;
        state_n         = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset drops any in-flight transaction without installing.
    if (!reset) begin
      state_n         = IDLE;
      is_output_valid = 1'b0;
      is_hit          = 1'b0;
      dout            = '0;
      mem_req_valid   = 1'b0;
      arr_we          = 1'b0;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: misses, hits, writeback,
// stalled memory, reset mid-miss and ignored requests.
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  din = '0;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_rdata = '0;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_req_valid && mem_req_ready) req_cnt++;

  data_cache dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_rdata  (mem_resp_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the cache in COMPARE for the issued request.
  task automatic issue(input logic [31:0] a, input logic rd,
                       input logic wr, input logic [31:0] d);
    int n = 0;
    while (!is_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (is_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_timeout addr=%h is_ready=%b exp=1", a, is_ready);
    end
    addr = a;
    mem_read = rd;
    mem_write = wr;
    din = d;
    is_input_valid = 1'b1;
    tick();
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (is_ready !== 1'b0) begin
      failures++; $display("FAIL rst_ready got=%b exp=0", is_ready);
    end
    checks++;
    if (is_output_valid !== 1'b0 || is_hit !== 1'b0) begin
      failures++;
      $display("FAIL rst_ov_hit got=%b%b exp=00", is_output_valid, is_hit);
    end
    checks++;
    if (dout !== 32'h0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_dout_req got=%h/%b exp=0/0", dout, mem_req_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (is_ready !== 1'b1) begin
      failures++; $display("FAIL rst_release_ready got=%b exp=1", is_ready);
    end
  endtask

  task automatic test_read_miss();
    int n0 = req_cnt;
    issue(32'h100, 1'b1, 1'b0, 32'h0);
    checks++;
    if (is_output_valid !== 1'b0) begin
      failures++; $display("FAIL miss_cmp_ov got=%b exp=0", is_output_valid);
    end
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL miss_alloc_req got=%b/%b/%h exp=1/0/00000100",
               mem_req_valid, mem_req_write, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || is_output_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_wait got=%b/%b exp=0/0", mem_req_valid, is_output_valid);
    end
    tick();
    mem_resp_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (is_output_valid !== 1'b1 || dout !== 32'h11 || is_hit !== 1'b0) begin
      failures++;
      $display("FAIL miss_resp got=%b/%h/%b exp=1/00000011/0",
               is_output_valid, dout, is_hit);
    end
    tick();
    checks++;
    if (req_cnt !== n0 + 1) begin
      failures++; $display("FAIL miss_req_count got=%0d exp=%0d", req_cnt, n0 + 1);
    end
  endtask

  task automatic test_hit();
    int n0 = req_cnt;
    issue(32'h104, 1'b1, 1'b0, 32'h0);
    checks++;
    if (is_output_valid !== 1'b1 || is_hit !== 1'b1 || dout !== 32'h22) begin
      failures++;
      $display("FAIL hit_read got=%b/%b/%h exp=1/1/00000022",
               is_output_valid, is_hit, dout);
    end
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL hit_no_req got=%b exp=0", mem_req_valid);
    end
    issue(32'h108, 1'b1, 1'b1, 32'h55);
    checks++;
    if (is_output_valid !== 1'b1 || is_hit !== 1'b1) begin
      failures++;
      $display("FAIL hit_rw_write got=%b/%b exp=1/1", is_output_valid, is_hit);
    end
    issue(32'h108, 1'b1, 1'b0, 32'h0);
    checks++;
    if (dout !== 32'h55 || is_hit !== 1'b1) begin
      failures++; $display("FAIL hit_rw_readback got=%h/%b exp=00000055/1", dout, is_hit);
    end
    tick();
    checks++;
    if (req_cnt !== n0) begin
      failures++; $display("FAIL hit_req_count got=%0d exp=%0d", req_cnt, n0);
    end
  endtask

  task automatic test_writeback();
    int bad = 0;
    issue(32'h100, 1'b0, 1'b1, 32'hDEADBEEF);
    checks++;
    if (is_hit !== 1'b1 || is_output_valid !== 1'b1) begin
      failures++; $display("FAIL wb_store_hit got=%b/%b exp=1/1", is_hit, is_output_valid);
    end
    issue(32'h200, 1'b1, 1'b0, 32'h0);
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL wb_req got=%b/%b/%h exp=1/1/00000100",
               mem_req_valid, mem_req_write, mem_req_addr);
    end
    checks++;
    if (mem_req_wdata[31:0] !== 32'hDEADBEEF || mem_req_wdata[95:64] !== 32'h55) begin
      failures++;
      $display("FAIL wb_data got=%h/%h exp=deadbeef/00000055",
               mem_req_wdata[31:0], mem_req_wdata[95:64]);
    end
    tick();
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_write !== 1'b1) begin
      failures++;
      $display("FAIL wb_stall got=%b/%h exp=1/00000100", mem_req_valid, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL wb_then_alloc got=%b/%b/%h exp=1/0/00000200",
               mem_req_valid, mem_req_write, mem_req_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200 || is_output_valid !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL alloc_stall unstable_cycles=%0d exp=0", bad);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_rdata = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (is_output_valid !== 1'b1 || dout !== 32'hA0 || is_hit !== 1'b0) begin
      failures++;
      $display("FAIL wb_fill_resp got=%b/%h/%b exp=1/000000a0/0",
               is_output_valid, dout, is_hit);
    end
    tick();
  endtask

  task automatic test_reset_mid_miss();
    int n0;
    issue(32'h300, 1'b1, 1'b0, 32'h0);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    reset = 1'b0;
    mem_resp_rdata = {4{32'hBAD0BAD0}};
    mem_resp_valid = 1'b1;
    tick();
    checks++;
    if (mem_req_valid !== 1'b0 || is_output_valid !== 1'b0 || is_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b/%b/%b exp=0/0/0",
               mem_req_valid, is_output_valid, is_ready);
    end
    tick();
    mem_resp_valid = 1'b0;
    reset = 1'b1;
    tick();
    n0 = req_cnt;
    issue(32'h300, 1'b1, 1'b0, 32'h0);
    checks++;
    if (is_output_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_miss got=%b exp=0", is_output_valid);
    end
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h300) begin
      failures++;
      $display("FAIL midrst_realloc got=%b/%b/%h exp=1/0/00000300",
               mem_req_valid, mem_req_write, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_rdata = {32'h33, 32'h32, 32'h31, 32'h30};
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (dout !== 32'h30 || is_hit !== 1'b0 || req_cnt !== n0 + 1) begin
      failures++;
      $display("FAIL midrst_resp got=%h/%b/%0d exp=00000030/0/%0d",
               dout, is_hit, req_cnt, n0 + 1);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    issue(32'h404, 1'b1, 1'b0, 32'h0);
    tick();
    is_input_valid = 1'b1;
    addr = 32'h500;
    mem_write = 1'b1;
    din = 32'h12345678;
    checks++;
    if (is_ready !== 1'b0) begin
      failures++; $display("FAIL busy_ready got=%b exp=0", is_ready);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    is_input_valid = 1'b0;
    mem_write = 1'b0;
    mem_resp_rdata = {32'h43, 32'h42, 32'h41, 32'h40};
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (is_output_valid !== 1'b1 || dout !== 32'h41 || is_hit !== 1'b0) begin
      failures++;
      $display("FAIL busy_orig_resp got=%b/%h/%b exp=1/00000041/0",
               is_output_valid, dout, is_hit);
    end
    tick();
    tick();
    checks++;
    if (is_output_valid !== 1'b0 || mem_req_valid !== 1'b0 || is_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_no_stray got=%b/%b/%b exp=0/0/1",
               is_output_valid, mem_req_valid, is_ready);
    end
    issue(32'h408, 1'b1, 1'b0, 32'h0);
    checks++;
    if (dout !== 32'h42 || is_hit !== 1'b1) begin
      failures++; $display("FAIL b2b_first got=%h/%b exp=00000042/1", dout, is_hit);
    end
    issue(32'h40C, 1'b1, 1'b0, 32'h0);
    checks++;
    if (dout !== 32'h43 || is_hit !== 1'b1) begin
      failures++; $display("FAIL b2b_second got=%h/%b exp=00000043/1", dout, is_hit);
    end
    issue(32'h500, 1'b1, 1'b0, 32'h0);
    checks++;
    if (is_output_valid !== 1'b0) begin
      failures++; $display("FAIL busy_not_installed got=%b exp=0", is_output_valid);
    end
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500) begin
      failures++;
      $display("FAIL busy_later_alloc got=%b/%h exp=1/00000500",
               mem_req_valid, mem_req_addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_miss();
    test_hit();
    test_writeback();
    test_reset_mid_miss();
    test_ignore_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of direct-mapped lines.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line; line width = 32*WORDS_PER_LINE bits.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port: is_input_valid  in  1  CPU request strobe.
REQ-007 SHALL have port: addr  in  32  byte address of the word.
REQ-008 SHALL have port: mem_read  in  1  load request.
REQ-009 SHALL have port: mem_write  in  1  store request.
REQ-010 SHALL have port: din  in  32  store data.
REQ-011 SHALL have port: is_ready  out  1  cache can accept a request this cycle.
REQ-012 SHALL have port: is_output_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: dout  out  32  load data, valid with is_output_valid.
REQ-014 SHALL have port: is_hit  out  1  lookup result, valid with is_output_valid.
REQ-015 SHALL have port: mem_req_valid  out  1  backing-memory request.
REQ-016 SHALL have port: mem_req_ready  in  1  backing memory accepts the request.
REQ-017 SHALL have port: mem_req_write  out  1  1 = line writeback, 0 = line fill.
REQ-018 SHALL have port: mem_req_addr  out  32  line-aligned address.
REQ-019 SHALL have port: mem_req_wdata  out  line  writeback data.
REQ-020 SHALL have port: mem_resp_valid  in  1  fill data valid.
REQ-021 SHALL have port: mem_resp_rdata  in  line  fill data.

Function
REQ-022 SHALL split addr into byte offset [1:0] (ignored), word offset, index and tag (remaining upper bits); defaults: word [3:2], index [7:4], tag [31:8].
REQ-023 SHALL be a direct-mapped, write-back, write-allocate cache with one valid bit and one dirty bit per line.
REQ-024 SHALL implement states IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND.
REQ-025 SHALL assert is_ready only in IDLE and SHALL accept a request on is_input_valid & (mem_read | mem_write) & is_ready, latching addr, din and the request type.
REQ-026 SHALL treat mem_read & mem_write both high as a write.
REQ-027 SHALL ignore is_input_valid while is_ready = 0.
REQ-028 In COMPARE, SHALL complete a hit (valid & tag match) in the same cycle: is_output_valid = 1, is_hit = 1; a read drives dout; a write updates the word and sets dirty; the next state is IDLE. Hit latency is 1 cycle after acceptance.
REQ-029 On a miss, SHALL go to WRITEBACK if the victim is valid & dirty, otherwise to ALLOCATE.
REQ-030 WRITEBACK SHALL hold mem_req_valid = 1, mem_req_write = 1, victim address and data stable until mem_req_ready = 1, then go to ALLOCATE.
REQ-031 ALLOCATE SHALL hold mem_req_valid = 1, mem_req_write = 0 until mem_req_ready, SHALL drop mem_req_valid and wait for mem_resp_valid, SHALL install the line (valid = 1, dirty = 0, new tag), then go to RESPOND.
REQ-032 RESPOND SHALL perform the access on the filled line, pulse is_output_valid with is_hit = 0, set dirty on a write, and return to IDLE.
REQ-033 SHALL hold mem_req_valid = 0 outside WRITEBACK and ALLOCATE, and SHALL ignore mem_resp_valid outside ALLOCATE.
REQ-034 SHALL tolerate mem_req_ready being held low for any number of cycles without changing request fields.

Reset
REQ-035 While reset = 0 at a clock edge, SHALL enter IDLE and clear all valid and dirty bits.
REQ-036 During reset, outputs SHALL be is_ready = 0, is_output_valid = 0, is_hit = 0, dout = 0, and mem_req_valid = 0.
REQ-037 Reset asserted mid-miss SHALL abandon the outstanding memory transaction with no line install.

Structure
REQ-038 A shared package SHALL hold the state enumeration and the default field-width constants.
REQ-039 Tag/data/valid/dirty storage SHALL be one sub-module, cache_line_array, with one combinational read port and one synchronous write port.

Verification
REQ-040 After reset, read 0x100 with the fill line {0x44,0x33,0x22,0x11} -> one ALLOCATE request at address 0x100, then dout = 0x11, is_hit = 0.
REQ-041 Read 0x104 immediately after REQ-040 -> is_output_valid one cycle after acceptance, dout = 0x22, is_hit = 1, no memory request.
REQ-042 Write 0xDEADBEEF to 0x100, then read 0x200 (same index) -> WRITEBACK at address 0x100 with word 0 = 0xDEADBEEF, followed by ALLOCATE at address 0x200.
REQ-043 Hold mem_req_ready low for 5 cycles during ALLOCATE -> mem_req_valid and mem_req_addr remain stable, and is_output_valid stays low until the fill completes.
REQ-044 Assert reset while waiting for mem_resp_valid, then read the same address -> miss (is_hit = 0) and a new ALLOCATE request is issued.
REQ-045 Assert is_input_valid during a miss with a different address -> the request is ignored, and only the original request completes.
